// File: rtl/alm_dot_acc.sv
// Batched dot-product accumulator fed by an ALM-SOA approximate log multiplier.
// Operand register -> product register -> running sum, with a valid/ready batch result port.
module alm_dot_acc #(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ACC_W   = 20,
  localparam int unsigned CntW   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [8:0]       x,
  input  logic [8:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CntW-1:0]  out_terms
);

  if (N_TERMS == 0 || ACC_W < 17 + $clog2(N_TERMS)) begin : g_param_check
    $error("alm_dot_acc: need N_TERMS >= 1 and ACC_W >= 17 + clog2(N_TERMS)");
  end

  typedef enum logic [1:0] {StAcc, StWait, StHold} state_e;

  // Mitchell log multiply on sign-magnitude operands. The fraction adder LSB is a set-one
  // stage (forced to 1, no carry into the upper bits). Only -256 * -256 exceeds 16 bits of
  // magnitude, so the magnitude is clamped to keep the product in 17-bit two's complement.
  function automatic logic [16:0] alm_soa(input logic [8:0] a, input logic [8:0] b);
    logic [8:0]  ma, mb;
    logic [3:0]  ka, kb;
    logic [7:0]  fa, fb, frac;
    logic [8:0]  fsum;
    logic [4:0]  e;
    logic [25:0] wide;
    logic [17:0] mag;
    logic [15:0] mag_sat;
    ma = a[8] ? 9'(-a) : a;
    mb = b[8] ? 9'(-b) : b;
    ka = 4'd0;
    kb = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (ma[i]) ka = 4'(i);
      if (mb[i]) kb = 4'(i);
    end
    fa      = 8'(ma << (4'd8 - ka));
    fb      = 8'(mb << (4'd8 - kb));
    fsum    = {1'b0, fa & 8'hFE} + {1'b0, fb & 8'hFE};
    frac    = fsum[7:0] | 8'h01;
    e       = 5'(ka) + 5'(kb) + 5'(fsum[8]);
    wide    = 26'({1'b1, frac}) << e;
    mag     = 18'(wide >> 8);
    mag_sat = (|mag[17:16]) ? 16'hFFFF : mag[15:0];
    if (ma == 9'd0 || mb == 9'd0) alm_soa = '0;
    else if (a[8] ^ b[8])         alm_soa = 17'(-{1'b0, mag_sat});
    else                          alm_soa = {1'b0, mag_sat};
  endfunction

  state_e            state_q, state_d;
  logic [8:0]        x1_q, y1_q;
  logic              last1_q, v1_q;
  logic [16:0]       p2_q, p1;
  logic              last2_q, v2_q;
  logic [ACC_W-1:0]  sum_q, sum_d, sum_next, p_ext;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   terms_q, terms_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, term_last;

  assign in_ready  = (state_q == StAcc);
  assign accept    = in_valid & in_ready;
  assign term_last = in_last | (cnt_q == CntW'(N_TERMS - 1));
  assign p1        = alm_soa(x1_q, y1_q);
  assign p_ext     = ACC_W'($signed(p2_q));
  assign sum_next  = sum_q + p_ext;

  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign out_terms = terms_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    terms_d     = terms_q;
    out_valid_d = out_valid_q;
    if (v2_q) sum_d = sum_next;
    case (state_q)
      StAcc: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (term_last) state_d = StWait;
        end
      end
      StWait: begin
        if (v2_q && last2_q) begin
          acc_d       = sum_next;
          terms_d     = cnt_q;
          out_valid_d = 1'b1;
          sum_d       = '0;
          cnt_d       = '0;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      x1_q        <= '0;
      y1_q        <= '0;
      last1_q     <= 1'b0;
      v1_q        <= 1'b0;
      p2_q        <= '0;
      last2_q     <= 1'b0;
      v2_q        <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      terms_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= accept;
      if (accept) begin
        x1_q    <= x;
        y1_q    <= y;
        last1_q <= term_last;
      end
      v2_q        <= v1_q;
      if (v1_q) begin
        p2_q    <= p1;
        last2_q <= last1_q;
      end
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      terms_q     <= terms_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alm_dot_acc.sv
// Self-checking bench for alm_dot_acc: directed batches plus random batches scored against
// an arithmetic model of the ALM-SOA multiplier.
module tb_alm_dot_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [8:0]  x;
  logic [8:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] acc;
  logic [3:0]  out_terms;

  int errors = 0;
  int checks = 0;
  int exp_sum;
  int exp_n;

  alm_dot_acc #(
    .N_TERMS(8),
    .ACC_W  (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc      (acc),
    .out_terms(out_terms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mitchell product: log2(a) ~ k + f, fractions summed with the LSB forced to 1,
  // antilog truncated to an integer, magnitude clamped to 16 bits.
  function automatic int gold(input int a, input int b);
    int     ma, mb, ka, kb, fa, fb, s, e;
    longint mag;
    if (a == 0 || b == 0) return 0;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    ka = 0;
    while ((1 << (ka + 1)) <= ma) ka++;
    kb = 0;
    while ((1 << (kb + 1)) <= mb) kb++;
    fa  = ((ma - (1 << ka)) * 256) / (1 << ka);
    fb  = ((mb - (1 << kb)) * 256) / (1 << kb);
    s   = (fa / 2 + fb / 2) * 2 + 1;
    e   = ka + kb + ((s >= 256) ? 1 : 0);
    mag = (longint'(256 + s % 256) << e) / 256;
    if (mag > 65535) mag = 65535;
    return ((a < 0) != (b < 0)) ? -int'(mag) : int'(mag);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic new_batch();
    exp_sum = 0;
    exp_n   = 0;
  endtask

  task automatic send_pair(input int a, input int b, input logic last);
    int n = 0;
    x        = 9'(a);
    y        = 9'(b);
    in_last  = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_sum += gold(a, b);
    exp_n++;
  endtask

  task automatic wait_result(input string tag, input logic [19:0] ea, input int et);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_acc"}, {12'd0, acc}, {12'd0, ea});
    chk({tag, "_terms"}, {28'd0, out_terms}, 32'(et));
  endtask

  initial begin
    int len, a, b;
    logic lst;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    x         = 9'd5;
    y         = 9'd5;
    out_ready = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc", {12'd0, acc}, 32'd0);
    chk("rst_terms", {28'd0, out_terms}, 32'd0);

    // Full batch with exact timing.
    out_ready = 1'b1;
    new_batch();
    for (int i = 0; i < 8; i++) send_pair(8, 2, 1'b0);
    chk("full_in_ready_k1", {31'd0, in_ready}, 32'd0);
    chk("full_valid_k1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("full_valid_k2", {31'd0, out_valid}, 32'd0);
    chk("full_in_ready_k2", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_valid_k3", {31'd0, out_valid}, 32'd1);
    chk("full_acc", {12'd0, acc}, 32'd128);
    chk("full_terms", {28'd0, out_terms}, 32'd8);
    chk("full_in_ready_k3", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_pulse_end", {31'd0, out_valid}, 32'd0);
    chk("full_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Signed interleave.
    new_batch();
    for (int i = 0; i < 4; i++) begin
      send_pair(-4, 16, 1'b0);
      send_pair(1, 1, 1'b0);
    end
    wait_result("signed", 20'hFFF04, 8);
    tick();

    // Early termination, then a fresh one-term batch.
    new_batch();
    send_pair(2, 64, 1'b0);
    send_pair(2, 64, 1'b0);
    send_pair(2, 64, 1'b1);
    wait_result("early", 20'd384, 3);
    tick();
    new_batch();
    send_pair(1, 1, 1'b1);
    wait_result("one_term", 20'd1, 1);
    tick();

    // Backpressure while in_valid toggles.
    out_ready = 1'b0;
    new_batch();
    send_pair(8, 2, 1'b0);
    send_pair(8, 2, 1'b1);
    wait_result("bp", 20'd32, 2);
    x = 9'd7;
    y = 9'd7;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_acc_hold", {12'd0, acc}, 32'd32);
      chk("bp_terms_hold", {28'd0, out_terms}, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    new_batch();
    send_pair(1, 1, 1'b1);
    wait_result("bp_no_leak", 20'd1, 1);
    tick();

    // Reset mid-batch, then a full batch ending with in_last on the last term.
    new_batch();
    for (int i = 0; i < 4; i++) send_pair(0, 18, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_acc", {12'd0, acc}, 32'd0);
    new_batch();
    for (int i = 0; i < 8; i++) send_pair(1, 1, (i == 7));
    wait_result("after_rst", 20'd8, 8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_term_end", {31'd0, out_valid}, 32'd0);
    end

    // All-zero products and the saturating corner.
    new_batch();
    send_pair(0, -7, 1'b0);
    send_pair(5, 0, 1'b1);
    wait_result("zeros", 20'd0, 2);
    tick();
    new_batch();
    for (int i = 0; i < 8; i++) send_pair(-256, -256, 1'b0);
    wait_result("sat_corner", 20'(exp_sum), exp_n);
    tick();

    // Random signed batches with stalls.
    for (int bt = 0; bt < 16; bt++) begin
      len = $urandom_range(1, 8);
      out_ready = $urandom_range(0, 1);
      new_batch();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        a   = int'($urandom_range(0, 511)) - 256;
        b   = int'($urandom_range(0, 511)) - 256;
        lst = (i == len - 1) && (len < 8 || $urandom_range(0, 1) == 1);
        send_pair(a, b, lst);
      end
      wait_result("rand", 20'(exp_sum), exp_n);
      if (out_ready == 1'b0) begin
        repeat ($urandom_range(0, 3)) tick();
        out_ready = 1'b1;
      end
      tick();
      chk("rand_handshake", {31'd0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alm_dot_acc.md
Name: alm_dot_acc

Overview:
- Sequential dot-product stage directly downstream of the ALM_SOA approximate log multiplier.
- Accepts a stream of signed operand pairs over a valid/ready handshake and registers each pair into an internal ALM_SOA instance (x, y 9-bit; p 17-bit two's complement).
- Registers the product and accumulates a batch of up to N_TERMS products.
- Presents the batch sum on a valid/ready output port.

Parameters:
- N_TERMS, 8, maximum products per batch; must be >= 1.
- ACC_W, 20, accumulator/result width. Must satisfy ACC_W >= 17 + clog2(N_TERMS); otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_last  input  1  pair is final term of batch (early termination)
- x  input  9  operand A, two's complement
- y  input  9  operand B, two's complement
- out_valid  output  1  batch result valid
- out_ready  input  1  consumer accepts result
- acc  output  ACC_W  batch sum, two's complement
- out_terms  output  clog2(N_TERMS+1)  number of terms in the batch

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - in_ready=1, out_valid=0, acc=0, out_terms=0.
  - All pipeline valids, term counter and accumulator cleared; state=ACC.
- Reset mid-batch discards all partial state. No result is produced for the aborted batch.
- Acceptance: a pair is accepted on a rising edge with in_valid & in_ready. x, y and in_last are ignored otherwise.
- Pipeline:
  - S1 registers x, y, last, v1 on acceptance.
  - ALM_SOA is combinational on the S1 registers.
  - S2 registers p, last, v2 one cycle later.
  - The accumulate step consumes S2 on the following edge.
- Latency: the final term accepted at edge k makes out_valid=1 after edge k+2. Throughput is one pair per cycle within a batch.
- Arithmetic:
  - Each p is sign-extended from 17 to ACC_W bits and added to the running sum.
  - No saturation; the width rule guarantees no overflow.
  - Products are exactly the ALM_SOA outputs. The block does not correct the approximation.
- FSM:
  - ACC: in_ready=1. Count accepted terms. On accepting the N_TERMS-th pair, or any pair with in_last=1, go to WAIT.
  - WAIT: in_ready=0 while the pipeline drains. When the final term is accumulated, load acc = sum, load out_terms = count, set out_valid=1, clear the internal sum and count, and go to HOLD.
  - HOLD: in_ready=0. acc and out_terms stay stable while out_valid=1. On out_valid & out_ready, clear out_valid and go to ACC; in_ready=1 from the next cycle.
- Boundary conditions:
  - in_last=1 on the first pair gives a one-term batch, out_terms=1.
  - in_last=1 on the N_TERMS-th pair gives a single termination, not two.
  - in_valid during WAIT/HOLD is ignored; no term is lost or double-counted.
  - out_ready held high gives a result pulse of exactly one cycle.
  - out_ready asserted while out_valid=0 has no effect.
  - A zero operand yields a contribution of 0, per ALM_SOA.
  - A batch of all-zero products still produces out_valid with acc=0.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, acc=0, out_terms=0 after release; nothing accumulated.
2. Full batch: 8 consecutive pairs x=8, y=2, out_ready=1 -> out_valid for one cycle starting 2 cycles after the 8th accept; acc=128, out_terms=8; in_ready=0 from after the 8th accept until the handshake.
3. Signed: 4x (x=-4, y=16) interleaved with 4x (x=1, y=1) -> acc=-252 (20'hFFF04), out_terms=8.
4. Early end: 3 pairs x=2, y=64 with in_last=1 on the 3rd -> acc=384, out_terms=3; next batch starts fresh at 0.
5. Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid toggles -> acc, out_terms and out_valid stable; in_ready=0; zero pairs accepted. Then out_ready=1 -> handshake; in_ready=1 on the next cycle.
6. Reset mid-batch after 4 pairs of x=0, y=18, then a full batch of x=1, y=1 -> no output for the aborted batch; acc=8, out_terms=8.
7. Random signed batches with random stalls -> acc equals the sum of sign-extended outputs from a golden ALM_SOA instance.
